// File: rtl/lsb_serial_deserializer_if.sv
// Handshake bundle between the serial bit source, the deserializer and the word consumer.
// The deserializer takes the slave modport; the source/consumer side takes master.
interface lsb_serial_deserializer_if #(
  parameter int WIDTH = 128,
  parameter int CNT_W = 8
);
  logic             bit_in;
  logic             bit_valid;
  logic             bit_ready;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;
  logic [CNT_W-1:0] bit_count;
  logic             parity_err;

  modport slave (
    input  bit_in, bit_valid, word_ready,
    output bit_ready, word_out, word_valid, bit_count, parity_err
  );

  modport master (
    output bit_in, bit_valid, word_ready,
    input  bit_ready, word_out, word_valid, bit_count, parity_err
  );
endinterface

// File: rtl/lsb_serial_deserializer.sv
// LSB-first serial-to-parallel deserializer with a one-entry valid/ready output buffer.
// Define DESER_PARITY_EN to append one even-parity bit per frame and report parity_err.
//
// state   | meaning
// S_FILL  | accepting bits into the accumulator (bit_ready=1)
// S_STALL | accumulator holds a full frame, waiting for the buffer to drain (bit_ready=0)
module lsb_serial_deserializer #(
  parameter int WIDTH = 128,
  parameter int CNT_W = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  lsb_serial_deserializer_if.slave   bus
);

`ifdef DESER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME - 1);

  typedef enum logic {S_FILL, S_STALL} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             wv_q, wv_d;
  logic             bit_ready_q, bit_ready_d;
  logic             accept;
  logic             drain;
`ifdef DESER_PARITY_EN
  logic             perr_q, perr_d;
  logic             pend_q, pend_d;
  logic             err_now;
`endif

  assign accept = bus.bit_valid && bit_ready_q;
  assign drain  = wv_q && bus.word_ready;
`ifdef DESER_PARITY_EN
  // When the parity bit arrives the accumulator already holds all data bits.
  assign err_now = (^acc_q) ^ bus.bit_in;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    wv_d    = wv_q;
`ifdef DESER_PARITY_EN
    perr_d  = perr_q;
    pend_d  = pend_q;
`endif
    if (drain) begin
      wv_d = 1'b0;
`ifdef DESER_PARITY_EN
      perr_d = 1'b0;
`endif
    end

    case (state_q)
      S_FILL: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
`ifdef DESER_PARITY_EN
          if (cnt_q < CNT_W'(WIDTH)) acc_d = {bus.bit_in, acc_q[WIDTH-1:1]};
`else
          acc_d = {bus.bit_in, acc_q[WIDTH-1:1]};
`endif
          if (cnt_q == LAST) begin
            // Transfer immediately if the buffer is empty or being drained this edge.
            if (!wv_q || bus.word_ready) begin
              word_d = acc_d;
              wv_d   = 1'b1;
              cnt_d  = '0;
`ifdef DESER_PARITY_EN
              perr_d = err_now;
`endif
            end else begin
              state_d = S_STALL;
`ifdef DESER_PARITY_EN
              pend_d  = err_now;
`endif
            end
          end
        end
      end
      S_STALL: begin
        if (bus.word_ready) begin
          word_d  = acc_q;
          wv_d    = 1'b1;
          cnt_d   = '0;
          state_d = S_FILL;
`ifdef DESER_PARITY_EN
          perr_d  = pend_q;
`endif
        end
      end
      default: state_d = S_FILL;
    endcase

    bit_ready_d = (state_d == S_FILL);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_FILL;
      acc_q       <= '0;
      cnt_q       <= '0;
      word_q      <= '0;
      wv_q        <= 1'b0;
      bit_ready_q <= 1'b1;
`ifdef DESER_PARITY_EN
      perr_q      <= 1'b0;
      pend_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      wv_q        <= wv_d;
      bit_ready_q <= bit_ready_d;
`ifdef DESER_PARITY_EN
      perr_q      <= perr_d;
      pend_q      <= pend_d;
`endif
    end
  end

  assign bus.bit_ready  = bit_ready_q;
  assign bus.word_out   = word_q;
  assign bus.word_valid = wv_q;
  assign bus.bit_count  = cnt_q;
`ifdef DESER_PARITY_EN
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule
